// File: rtl/uart_status_tx.sv
// uart_status_tx
//   Status-reply UART transmitter. The control FSM requests a send, and this block
//   transmits one byte: the 6-bit memory state with a 2-bit tag in bits [7:6]. The byte
//   goes out LSB first on tx_line. Every output is registered.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> 8E1 framing; an even-parity bit is sent after b7 (11 bit-times)
//     undefined -> 8N1 framing (10 bit-times)
//
// Ports
//   in_clk    in   1  system clock, rising edge
//   in_rst    in   1  synchronous active-high reset
//   tx_start  in   1  send request (level); one frame per low->high request
//   tx_data   in   6  memory state, sampled only on the accept cycle
//   tx_busy   out  1  high from the cycle after accept until the end of the stop bit
//   tx_done   out  1  one-cycle pulse when a frame completes
//   tx_line   out  1  serial line, idle high
`timescale 1ns/1ps

module uart_status_tx #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter logic [1:0]  TAG    = 2'b00
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       tx_start,
    input  logic [5:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_line
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             baud_tick;

    assign baud_tick = (baud_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        armed_d = armed_q;
        line_d  = line_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        // Free-running within a frame; held at zero while idle so accept starts a full bit.
        baud_d = (state_q == ST_IDLE || baud_tick) ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tx_start && armed_q) begin
                    shift_d = {TAG, tx_data};
                    armed_d = 1'b0;
                    state_d = ST_START;
                    busy_d  = 1'b1;
                    line_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^{TAG, tx_data};
`endif
                end else if (!tx_start) begin
                    // Re-arm only after the requester has dropped its level.
                    armed_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    line_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        line_d  = parity_q;
`else
                        state_d = ST_STOP;
                        line_d  = 1'b1;
`endif
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        line_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d = ST_STOP;
                    line_d  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    line_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            armed_q <= 1'b1;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx_line = line_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule
